// File: rtl/issue_scheduler_if.sv
// ---------------------------------------------------------------------------
// issue_scheduler_if
//
// Purpose: bundles the parser-facing, execution-port-facing and writeback
// signals of the dual-issue scheduler into one interface.
//
// Signals:
//   flush_i, in_valid_i         - flush request and bundle-valid from parser
//   *_i1 / *_i2                 - slot 1 (older, A) and slot 2 (younger, B)
//   port_ready_i[1:0]           - per-port acceptance from execution ports
//   wb_valid_i, wb_reg_i        - writeback notification
//   stall_o                     - back-pressure to the parser
//   issue_*_o0 / issue_*_o1     - registered per-port issued instruction
//   busy_o                      - scoreboard busy vector
//
// Modports:
//   slave  - the scheduler itself
//   master - the environment (parser, execution ports, writeback)
// ---------------------------------------------------------------------------
interface issue_scheduler_if #(
    parameter int NUM_REGS = 32
);
    localparam int REG_W = $clog2(NUM_REGS);

    logic                flush_i;
    logic                in_valid_i;
    logic                isBranch_i1;
    logic                isBranch_i2;
    logic                format_i1;
    logic                format_i2;
    logic [6:0]          opcode_i1;
    logic [6:0]          opcode_i2;
    logic [REG_W-1:0]    reg_i1;
    logic [REG_W-1:0]    reg_i2;
    logic [15:0]         operand_i1;
    logic [15:0]         operand_i2;
    logic [1:0]          port_ready_i;
    logic                wb_valid_i;
    logic [REG_W-1:0]    wb_reg_i;

    logic                stall_o;
    logic [1:0]          issue_valid_o;
    logic                issue_isBranch_o0;
    logic                issue_isBranch_o1;
    logic                issue_format_o0;
    logic                issue_format_o1;
    logic [6:0]          issue_opcode_o0;
    logic [6:0]          issue_opcode_o1;
    logic [REG_W-1:0]    issue_reg_o0;
    logic [REG_W-1:0]    issue_reg_o1;
    logic [15:0]         issue_operand_o0;
    logic [15:0]         issue_operand_o1;
    logic [NUM_REGS-1:0] busy_o;

    modport slave (
        input  flush_i, in_valid_i,
        input  isBranch_i1, isBranch_i2, format_i1, format_i2,
        input  opcode_i1, opcode_i2, reg_i1, reg_i2, operand_i1, operand_i2,
        input  port_ready_i, wb_valid_i, wb_reg_i,
        output stall_o, issue_valid_o,
        output issue_isBranch_o0, issue_isBranch_o1,
        output issue_format_o0, issue_format_o1,
        output issue_opcode_o0, issue_opcode_o1,
        output issue_reg_o0, issue_reg_o1,
        output issue_operand_o0, issue_operand_o1,
        output busy_o
    );

    modport master (
        output flush_i, in_valid_i,
        output isBranch_i1, isBranch_i2, format_i1, format_i2,
        output opcode_i1, opcode_i2, reg_i1, reg_i2, operand_i1, operand_i2,
        output port_ready_i, wb_valid_i, wb_reg_i,
        input  stall_o, issue_valid_o,
        input  issue_isBranch_o0, issue_isBranch_o1,
        input  issue_format_o0, issue_format_o1,
        input  issue_opcode_o0, issue_opcode_o1,
        input  issue_reg_o0, issue_reg_o1,
        input  issue_operand_o0, issue_operand_o1,
        input  busy_o
    );
endinterface

// File: rtl/issue_scheduler.sv
// ---------------------------------------------------------------------------
// issue_scheduler
//
// Purpose: in-order dual-issue scheduler. Latches a two-instruction bundle
// (A older, B younger), checks hazards against a busy scoreboard and between
// the two slots, and issues oldest-first on execution ports 0 and 1.
//
// Ports:
//   clock_i   - clock, rising edge
//   reset_ni  - asynchronous active-low reset
//   bus       - issue_scheduler_if.slave (bundle in, issue out, writeback,
//               stall and scoreboard debug vector)
// ---------------------------------------------------------------------------
module issue_scheduler #(
    parameter int NUM_REGS = 32
) (
    input  logic              clock_i,
    input  logic              reset_ni,
    issue_scheduler_if.slave  bus
);
    localparam int REG_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        EMPTY,
        PAIR,
        SINGLE
    } state_e;

    typedef struct packed {
        logic             isBranch;
        logic             format;
        logic [6:0]       opcode;
        logic [REG_W-1:0] regIdx;
        logic [15:0]      operand;
    } instr_t;

    state_e              state_q, state_d;
    instr_t              instA_q, instB_q;
    instr_t              issue0_q, issue1_q;
    logic [1:0]          issueValid_q;
    logic [NUM_REGS-1:0] busy_q, busy_d;

    instr_t inA, inB, oldest;
    logic   issue0, issue1, allDrain, stall, capture;
    logic   bReadsADest;

    // Register-form instructions also read operand[4:0]; reg is always read.
    function automatic logic srcBusy(input instr_t i, input logic [NUM_REGS-1:0] b);
        return b[i.regIdx] | (~i.format & b[i.operand[REG_W-1:0]]);
    endfunction

    // Branches have no destination, so they can never create a WAW hazard.
    function automatic logic dstBusy(input instr_t i, input logic [NUM_REGS-1:0] b);
        return ~i.isBranch & b[i.regIdx];
    endfunction

    assign inA = '{isBranch: bus.isBranch_i1, format: bus.format_i1,
                   opcode: bus.opcode_i1, regIdx: bus.reg_i1,
                   operand: bus.operand_i1};
    assign inB = '{isBranch: bus.isBranch_i2, format: bus.format_i2,
                   opcode: bus.opcode_i2, regIdx: bus.reg_i2,
                   operand: bus.operand_i2};

    // Issue decision, acceptance and next state. A flush suppresses issue
    // and capture, so the only thing that can change busy during a flush is
    // an in-flight writeback.
    always_comb begin
        oldest      = (state_q == PAIR) ? instA_q : instB_q;
        bReadsADest = (instB_q.regIdx == instA_q.regIdx) ||
                      (!instB_q.format && (instB_q.operand[REG_W-1:0] == instA_q.regIdx));

        issue0 = !bus.flush_i && (state_q != EMPTY) && bus.port_ready_i[0] &&
                 !srcBusy(oldest, busy_q) && !dstBusy(oldest, busy_q);

        issue1 = (state_q == PAIR) && issue0 && bus.port_ready_i[1] &&
                 !instA_q.isBranch && !bReadsADest &&
                 !(!instB_q.isBranch && (instB_q.regIdx == instA_q.regIdx)) &&
                 !dstBusy(instB_q, busy_q) && !srcBusy(instB_q, busy_q);

        case (state_q)
            PAIR:    allDrain = issue0 && issue1;
            SINGLE:  allDrain = issue0;
            default: allDrain = 1'b1;
        endcase

        stall   = !bus.flush_i && !allDrain;
        capture = bus.in_valid_i && !stall && !bus.flush_i;

        state_d = state_q;
        if (bus.flush_i) begin
            state_d = EMPTY;
        end else if (capture) begin
            state_d = PAIR;
        end else begin
            case (state_q)
                PAIR:    state_d = issue1 ? EMPTY : (issue0 ? SINGLE : PAIR);
                SINGLE:  state_d = issue0 ? EMPTY : SINGLE;
                default: state_d = EMPTY;
            endcase
        end

        // Clear first, then set, so a same-edge set on the written-back
        // register wins.
        busy_d = busy_q;
        if (bus.wb_valid_i) begin
            busy_d[bus.wb_reg_i] = 1'b0;
        end
        if (issue0 && !oldest.isBranch) begin
            busy_d[oldest.regIdx] = 1'b1;
        end
        if (issue1 && !instB_q.isBranch) begin
            busy_d[instB_q.regIdx] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Hold buffer, registered issue outputs and scoreboard.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= EMPTY;
            instA_q      <= '0;
            instB_q      <= '0;
            issue0_q     <= '0;
            issue1_q     <= '0;
            issueValid_q <= '0;
            busy_q       <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            issueValid_q <= {issue1, issue0};
            issue0_q     <= issue0 ? oldest  : '0;
            issue1_q     <= issue1 ? instB_q : '0;
            if (capture) begin
                instA_q <= inA;
                instB_q <= inB;
            end
        end
    end

    assign bus.stall_o           = stall;
    assign bus.issue_valid_o     = issueValid_q;
    assign bus.issue_isBranch_o0 = issue0_q.isBranch;
    assign bus.issue_isBranch_o1 = issue1_q.isBranch;
    assign bus.issue_format_o0   = issue0_q.format;
    assign bus.issue_format_o1   = issue1_q.format;
    assign bus.issue_opcode_o0   = issue0_q.opcode;
    assign bus.issue_opcode_o1   = issue1_q.opcode;
    assign bus.issue_reg_o0      = issue0_q.regIdx;
    assign bus.issue_reg_o1      = issue1_q.regIdx;
    assign bus.issue_operand_o0  = issue0_q.operand;
    assign bus.issue_operand_o1  = issue1_q.operand;
    assign bus.busy_o            = busy_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_issue_scheduler
//
// Purpose: directed self-checking bench for issue_scheduler. Each step drives
// a bundle or control change and compares outputs against hand-computed
// values.
// ---------------------------------------------------------------------------
module tb_issue_scheduler;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    issue_scheduler_if #(.NUM_REGS(32)) bus ();

    issue_scheduler #(.NUM_REGS(32)) dut (
        .clock_i  (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive a bundle onto the slot inputs; opcodes are fixed per slot.
    task automatic applyStimulus(input logic v,
                                 input logic brA, input logic fmtA,
                                 input logic [4:0] rA, input logic [15:0] opA,
                                 input logic brB, input logic fmtB,
                                 input logic [4:0] rB, input logic [15:0] opB);
        bus.in_valid_i  = v;
        bus.isBranch_i1 = brA;
        bus.format_i1   = fmtA;
        bus.opcode_i1   = 7'h11;
        bus.reg_i1      = rA;
        bus.operand_i1  = opA;
        bus.isBranch_i2 = brB;
        bus.format_i2   = fmtB;
        bus.opcode_i2   = 7'h22;
        bus.reg_i2      = rB;
        bus.operand_i2  = opB;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 5'd0, 16'd0);
    endtask

    // One-cycle writeback of register r.
    task automatic writeBack(input logic [4:0] r);
        bus.wb_valid_i = 1'b1;
        bus.wb_reg_i   = r;
        tick();
        bus.wb_valid_i = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.flush_i      = 1'b0;
        bus.port_ready_i = 2'b11;
        bus.wb_valid_i   = 1'b0;
        bus.wb_reg_i     = 5'd0;
        idle();

        #2;
        checkOutput("reset_valid", 32'(bus.issue_valid_o), 32'h0);
        checkOutput("reset_busy", bus.busy_o, 32'h0);
        checkOutput("reset_stall", 32'(bus.stall_o), 32'h0);
        checkOutput("reset_opcode0", 32'(bus.issue_opcode_o0), 32'h0);
        #10;
        rst_n = 1'b1;
        tick();

        // Independent pair issues on both ports one edge after capture.
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd1, 16'd5, 1'b0, 1'b0, 5'd2, 16'd3);
        #1 checkOutput("ind_stall_capture", 32'(bus.stall_o), 32'h0);
        tick();
        idle();
        #1 checkOutput("ind_stall_pair", 32'(bus.stall_o), 32'h0);
        tick();
        checkOutput("ind_valid", 32'(bus.issue_valid_o), 32'h3);
        checkOutput("ind_reg0", 32'(bus.issue_reg_o0), 32'd1);
        checkOutput("ind_operand0", 32'(bus.issue_operand_o0), 32'd5);
        checkOutput("ind_format0", 32'(bus.issue_format_o0), 32'd1);
        checkOutput("ind_opcode0", 32'(bus.issue_opcode_o0), 32'h11);
        checkOutput("ind_reg1", 32'(bus.issue_reg_o1), 32'd2);
        checkOutput("ind_operand1", 32'(bus.issue_operand_o1), 32'd3);
        checkOutput("ind_opcode1", 32'(bus.issue_opcode_o1), 32'h22);
        checkOutput("ind_busy", bus.busy_o, 32'h6);
        checkOutput("ind_stall_after", 32'(bus.stall_o), 32'h0);
        tick();
        checkOutput("ind_valid_once", 32'(bus.issue_valid_o), 32'h0);
        writeBack(5'd1);
        writeBack(5'd2);
        checkOutput("ind_busy_clear", bus.busy_o, 32'h0);

        // Intra-bundle RAW: B reads A's destination r4.
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd4, 16'd9, 1'b0, 1'b0, 5'd5, 16'd4);
        tick();
        idle();
        #1 checkOutput("raw_stall_pair", 32'(bus.stall_o), 32'h1);
        tick();
        checkOutput("raw_valid_a", 32'(bus.issue_valid_o), 32'h1);
        checkOutput("raw_reg0_a", 32'(bus.issue_reg_o0), 32'd4);
        checkOutput("raw_busy_a", bus.busy_o, 32'h10);
        checkOutput("raw_stall_single", 32'(bus.stall_o), 32'h1);
        tick();
        checkOutput("raw_wait", 32'(bus.issue_valid_o), 32'h0);
        writeBack(5'd4);
        checkOutput("raw_wb_edge_valid", 32'(bus.issue_valid_o), 32'h0);
        checkOutput("raw_wb_busy", bus.busy_o, 32'h0);
        checkOutput("raw_stall_free", 32'(bus.stall_o), 32'h0);
        tick();
        checkOutput("raw_valid_b", 32'(bus.issue_valid_o), 32'h1);
        checkOutput("raw_reg0_b", 32'(bus.issue_reg_o0), 32'd5);
        checkOutput("raw_operand0_b", 32'(bus.issue_operand_o0), 32'd4);
        checkOutput("raw_busy_b", bus.busy_o, 32'h20);
        writeBack(5'd5);

        // Make r7 busy; B writes r0 which must never become busy.
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd7, 16'd1, 1'b0, 1'b1, 5'd0, 16'd0);
        tick();
        idle();
        tick();
        checkOutput("r0_valid", 32'(bus.issue_valid_o), 32'h3);
        checkOutput("r0_busy", bus.busy_o, 32'h80);

        // Scoreboard WAW on r7: nothing issues until r7 is written back.
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd7, 16'd2, 1'b0, 1'b1, 5'd8, 16'd3);
        tick();
        idle();
        #1 checkOutput("waw_stall", 32'(bus.stall_o), 32'h1);
        tick();
        checkOutput("waw_none", 32'(bus.issue_valid_o), 32'h0);
        checkOutput("waw_stall_hold", 32'(bus.stall_o), 32'h1);
        writeBack(5'd7);
        checkOutput("waw_wb_edge_valid", 32'(bus.issue_valid_o), 32'h0);
        tick();
        checkOutput("waw_valid", 32'(bus.issue_valid_o), 32'h3);
        checkOutput("waw_reg0", 32'(bus.issue_reg_o0), 32'd7);
        checkOutput("waw_reg1", 32'(bus.issue_reg_o1), 32'd8);
        checkOutput("waw_busy", bus.busy_o, 32'h180);
        writeBack(5'd7);
        writeBack(5'd8);

        // Branch in slot A issues alone; B follows next edge on port 0.
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd9, 16'd0, 1'b0, 1'b1, 5'd10, 16'd0);
        tick();
        idle();
        tick();
        checkOutput("br_valid_a", 32'(bus.issue_valid_o), 32'h1);
        checkOutput("br_isbranch0", 32'(bus.issue_isBranch_o0), 32'h1);
        checkOutput("br_busy_a", bus.busy_o, 32'h0);
        tick();
        checkOutput("br_valid_b", 32'(bus.issue_valid_o), 32'h1);
        checkOutput("br_reg0_b", 32'(bus.issue_reg_o0), 32'd10);
        checkOutput("br_busy_b", bus.busy_o, 32'h400);
        writeBack(5'd10);

        // Port 1 not ready: A issues, B is held and then goes out on port 0.
        bus.port_ready_i = 2'b01;
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd11, 16'd0, 1'b0, 1'b0, 5'd12, 16'd13);
        tick();
        idle();
        #1 checkOutput("bp_stall", 32'(bus.stall_o), 32'h1);
        tick();
        checkOutput("bp_valid_a", 32'(bus.issue_valid_o), 32'h1);
        checkOutput("bp_reg0_a", 32'(bus.issue_reg_o0), 32'd11);
        bus.port_ready_i = 2'b11;
        tick();
        checkOutput("bp_valid_b", 32'(bus.issue_valid_o), 32'h1);
        checkOutput("bp_reg0_b", 32'(bus.issue_reg_o0), 32'd12);
        checkOutput("bp_operand0_b", 32'(bus.issue_operand_o0), 32'd13);
        checkOutput("bp_busy", bus.busy_o, 32'h1800);
        writeBack(5'd11);
        writeBack(5'd12);

        // Back-to-back bundles: a draining PAIR accepts the next bundle.
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd14, 16'd0, 1'b0, 1'b1, 5'd15, 16'd0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd16, 16'd0, 1'b0, 1'b1, 5'd17, 16'd0);
        #1 checkOutput("tp_stall", 32'(bus.stall_o), 32'h0);
        tick();
        idle();
        checkOutput("tp_reg0_first", 32'(bus.issue_reg_o0), 32'd14);
        checkOutput("tp_reg1_first", 32'(bus.issue_reg_o1), 32'd15);
        tick();
        checkOutput("tp_valid_second", 32'(bus.issue_valid_o), 32'h3);
        checkOutput("tp_reg0_second", 32'(bus.issue_reg_o0), 32'd16);
        checkOutput("tp_busy", bus.busy_o, 32'h3C000);

        // Flush during PAIR while a writeback of r14 is in flight.
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd20, 16'd0, 1'b0, 1'b1, 5'd21, 16'd0);
        tick();
        idle();
        bus.flush_i    = 1'b1;
        bus.wb_valid_i = 1'b1;
        bus.wb_reg_i   = 5'd14;
        #1 checkOutput("fl_stall", 32'(bus.stall_o), 32'h0);
        tick();
        bus.flush_i    = 1'b0;
        bus.wb_valid_i = 1'b0;
        checkOutput("fl_valid", 32'(bus.issue_valid_o), 32'h0);
        checkOutput("fl_busy", bus.busy_o, 32'h38000);
        #1 checkOutput("fl_stall_empty", 32'(bus.stall_o), 32'h0);
        tick();
        checkOutput("fl_no_late_issue", 32'(bus.issue_valid_o), 32'h0);

        // Reset asserted while B waits in SINGLE on r22.
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd22, 16'd0, 1'b0, 1'b0, 5'd23, 16'd22);
        tick();
        idle();
        tick();
        checkOutput("rs_valid_a", 32'(bus.issue_valid_o), 32'h1);
        checkOutput("rs_busy_a", bus.busy_o, 32'h438000);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rs_async_valid", 32'(bus.issue_valid_o), 32'h0);
        checkOutput("rs_async_busy", bus.busy_o, 32'h0);
        checkOutput("rs_async_reg0", 32'(bus.issue_reg_o0), 32'h0);
        checkOutput("rs_async_stall", 32'(bus.stall_o), 32'h0);
        #10 rst_n = 1'b1;
        tick();
        tick();
        checkOutput("rs_no_partial", 32'(bus.issue_valid_o), 32'h0);
        checkOutput("rs_stall_after", 32'(bus.stall_o), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/issue_scheduler.md
# issue_scheduler

In-order dual-issue scheduler between the instruction parser and the two execution ports. It latches each parsed two-instruction bundle and checks register hazards against a 32-entry busy scoreboard and between the two slots. It issues the instructions oldest-first on ports 0 and 1 and back-pressures the parser with `stall_o` while any instruction is held.

## Interface
- `NUM_REGS`, 32: number of architectural registers and scoreboard entries. The register index width is 5.
- `clock_i` input 1: clock; all state updates on the rising edge.
- `reset_ni` input 1: asynchronous, active-low reset.
- `flush_i` input 1: discards held instructions and clears issue outputs.
- `in_valid_i` input 1: a parsed bundle is present on the slot inputs.
- `isBranch_i1`/`isBranch_i2` input 1: slot branch flag.
- `format_i1`/`format_i2` input 1: 0 = register form, 1 = immediate form.
- `opcode_i1`/`opcode_i2` input 7: slot opcode.
- `reg_i1`/`reg_i2` input 5: destination register, which is also source A.
- `operand_i1`/`operand_i2` input 16: immediate when format=1; when format=0, bits [4:0] are source register B.
- `port_ready_i` input 2: bit p high means execution port p can accept an instruction this cycle.
- `wb_valid_i` input 1: writeback occurred.
- `wb_reg_i` input 5: register written back; its busy bit is cleared.
- `stall_o` output 1: the bundle on the inputs is not accepted this cycle (combinational).
- `issue_valid_o` output 2: bit p high means port p carries an issued instruction this cycle.
- `issue_isBranch_o0/1` output 1, `issue_format_o0/1` output 1, `issue_opcode_o0/1` output 7, `issue_reg_o0/1` output 5, `issue_operand_o0/1` output 16: per-port instruction fields.
- `busy_o` output 32: scoreboard busy vector, for debug and verification.

## Operation
- Hold buffer FSM states:
  - EMPTY: no instruction held.
  - PAIR: older instruction A and younger instruction B held.
  - SINGLE: only B remains.
- Sources: `reg` always. `operand[4:0]` only when format=0.
- Destination: `reg` when isBranch=0. Branches write no destination.
- Register 0 is never marked busy.
- Oldest-held instruction O (A in PAIR, B in SINGLE) can issue on port 0 when all of these hold:
  - `port_ready_i[0]`=1.
  - None of its sources is busy.
  - Its destination is not busy.
- B can issue on port 1 in PAIR only when all of these hold:
  - A issues this cycle.
  - `port_ready_i[1]`=1.
  - A is not a branch.
  - No B source equals A's destination.
  - B's destination differs from A's destination, and B's destination is not busy.
  - None of B's sources is busy.
- Transitions:
  - PAIR, both issue → EMPTY.
  - PAIR, only A issues → SINGLE.
  - PAIR, none issue → PAIR.
  - SINGLE, B issues → EMPTY.
  - SINGLE, B does not issue → SINGLE.
- Input acceptance:
  - `stall_o` = (state≠EMPTY) and not (all held instructions issue this cycle).
  - A bundle is captured into PAIR when `in_valid_i`=1 and `stall_o`=0. This is legal from any state whose contents fully drain this cycle.
- Scoreboard update at each edge:
  - Issuing sets the busy bit of each issued non-branch destination other than r0.
  - `wb_valid_i` clears busy[`wb_reg_i`].
  - If the same register is set and cleared at the same edge, set wins.
  - A writeback at an edge becomes visible to hazard checks only from the following cycle; there is no bypass.
- `flush_i`:
  - Forces state to EMPTY and `issue_valid_o` to 0 at the next edge.
  - No issue occurs and no bundle is captured at that edge, and `stall_o` is driven 0 during flush.
  - The scoreboard is retained: writebacks already in flight still clear it.
- Reset values: state EMPTY, `issue_valid_o`=0, all issue fields 0, `busy_o`=0, `stall_o`=0.

## Timing
- Bundle captured at edge E. Earliest issue is visible on `issue_*_o` in the cycle after edge E+1.
- Minimum latency from capture to issue is one cycle.
- Issue outputs are registered and valid for exactly one cycle per issued instruction. There is no port handshake beyond `port_ready_i`.
- Sustained throughput: one bundle per cycle when there are no hazards and both ports are ready.
- A busy bit is set at the same edge the issue outputs assert.
- Reset asserted mid-operation:
  - Immediately forces the reset values.
  - Held instructions are lost, with no partial issue.

## Test plan
- Independent pair: A = (reg 1, fmt 1, imm 5), B = (reg 2, fmt 0, src 3), both ports ready.
  - Required: both issue at E+1 on ports 0 and 1.
  - Required: `busy_o` = 0x6.
  - Required: `stall_o` stays 0.
- Intra-bundle RAW: A dst 4, B reg-form with source 4.
  - Required: A issues on port 0 at E+1 and `stall_o`=1 for that cycle.
  - Required: B waits in SINGLE until wb_reg=4 is seen, then issues on port 0 one cycle after the writeback edge.
- Scoreboard WAW: r7 busy, bundle A dst 7.
  - Required: `stall_o`=1 and nothing issues.
  - Stimulus: wb_reg=7 at edge W.
  - Required: A and B issue at edge W+1.
- Branch in slot A: isBranch_i1=1, B independent.
  - Required: A issues alone on port 0 with no busy bit set; B issues on the next edge on port 0.
- Port back-pressure: `port_ready_i`=2'b01 with an independent pair.
  - Required: A issues, B held.
  - Stimulus: ready becomes 2'b11.
  - Required: B issues on port 0.
- Flush during PAIR, then reset_ni low mid-SINGLE.
  - Required after flush: no issue, state EMPTY, busy bits retained.
  - Required after reset: all outputs 0 asynchronously.
